vec_exec_unit: RTL and testbench
================================

Name: vec_exec_unit

Overview:
- Multi-cycle vector execute stage, directly downstream of the decode/execute pipeline register.
- Consumes the two 256-bit vector operands, the 3-bit ALU opcode, the scalar operand and the destination register.
- Computes the result over 32 × 8-bit pixel lanes, LANES_PER_CYCLE lanes per cycle, holding the upstream pipeline via stall_o while busy.
- Delivers one registered result with a single-cycle valid pulse to the memory/writeback side.

Parameters:
- LANES_PER_CYCLE, 8, lanes processed per cycle; legal values 1, 2, 4, 8, 16, 32. N = 32/LANES_PER_CYCLE chunks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  vector instruction present in the decode/execute register
- flush_i  in  1  abort the current vector operation (branch taken)
- alu_op_i  in  3  vector opcode
- vrs1_i  in  256  vector operand A; lane i = bits [8i+7:8i]
- vrs2_i  in  256  vector operand B
- scalar_i  in  32  scalar operand; only [7:0] used
- rd_i  in  5  destination vector register
- stall_o  out  1  hold the upstream pipeline
- out_valid_o  out  1  result valid, one-cycle pulse
- result_o  out  256  vector result
- rd_o  out  5  destination, captured at accept
- wr_vec_o  out  1  vector register write enable, equals out_valid_o

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=1 at posedge):
  - State goes to IDLE; cnt=0.
  - result_o=0, rd_o=0, out_valid_o=0, wr_vec_o=0.
  - Reset overrides everything, including mid-BUSY.
- Accept (IDLE, start_i=1, flush_i=0):
  - Capture vrs1, vrs2, scalar[7:0], alu_op, rd into internal registers.
  - Go to BUSY with cnt=0.
- BUSY, each edge:
  - Write lanes [cnt·L .. cnt·L+L−1] of result_o, with L = LANES_PER_CYCLE.
  - Increment cnt.
  - When cnt==N−1, go to DONE.
- DONE: out_valid_o=1 and wr_vec_o=1 for exactly one cycle; next edge goes unconditionally to IDLE. start_i is ignored in DONE, because the upstream register still holds the just-finished instruction.
- stall_o (combinational) = (state==BUSY) | (state==IDLE & start_i & !flush_i).
  - stall_o=0 in DONE, so the pipeline advances.
- Latency: start sampled at edge k → out_valid_o high in the cycle after edge k+N.
  - stall_o is high for N+1 cycles.
  - Back-to-back vector instructions therefore have a period of N+2 cycles.
- flush_i:
  - In BUSY: next state IDLE, no valid pulse, result_o keeps its partially written contents.
  - In IDLE with start_i: flush_i wins; nothing is accepted.
  - In DONE: ignored.
- result_o, rd_o: hold their values between updates. Lanes not yet written retain the prior result.
- Opcodes (per 8-bit lane, a = operand A lane, b = operand B lane, s = scalar[7:0]):
  - 000 VADD: (a+b) mod 256
  - 001 VSUB: (a−b) mod 256
  - 010 VAVG: (a+b+1)>>1, 9-bit intermediate
  - 011 VMULS: (a·s)>>8, 16-bit intermediate
  - 100 VADDS: see Optional Feature
  - 101 VSHR: a >> s[2:0]
  - 110 PASSA: a
  - 111 PASSB: b

Optional Feature:
- Macro VEC_SAT_EN.
- Defined: opcode 100 is a saturating unsigned add, min(a+b, 255).
- Undefined: opcode 100 behaves identically to 000 (wrapping add); the saturation logic is not synthesised.

Decomposition:
- Package vec_pkg:
  - Constants VEC_W=256, LANE_W=8, NUM_LANES=32.
  - typedef enum logic [2:0] valu_op_e for the opcodes.
  - typedef enum vexec_state_e {IDLE, BUSY, DONE}.
  - typedef logic [LANE_W-1:0] lane_t.
- Sub-module vec_lane_alu: one combinational 8-bit lane (op, a, b, s → y), instantiated LANES_PER_CYCLE times and fed by a chunk mux indexed by cnt.

Test Plan:
- Reset mid-op: rst during BUSY with LPC=8 → next cycle IDLE, result_o=0, out_valid_o=0, stall_o=0.
- VAVG, LPC=8, all lanes a=0x10, b=0x21, start at edge k:
  - stall_o high for 5 cycles.
  - out_valid_o high only in the cycle after edge k+4.
  - All result lanes = 0x19; rd_o = rd_i captured at accept.
- VMULS, a=0xFF, s=0x80, LPC=1:
  - Lanes = 0x7F.
  - Latency 32 edges; exactly one valid pulse; no re-accept in DONE while start_i is still high.
- VADDS, a=0xF0, b=0x20:
  - With VEC_SAT_EN, lanes = 0xFF.
  - Without it, lanes = 0x10.
- flush_i asserted on the 2nd BUSY cycle (LPC=8) → IDLE, no out_valid_o pulse. flush_i and start_i together in IDLE → stall_o=0, no accept.
- Back-to-back VADD (0x01+0x02, then 0xFF+0x01) → results 0x03 then 0x00. Second accept occurs in the IDLE cycle after DONE; valid pulses 6 cycles apart with LPC=8.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector execute stage.
// Configuration macro VEC_SAT_EN (consumed by vec_lane_alu) selects saturating VADDS.
package vec_pkg;

  localparam int unsigned VEC_W     = 256;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 32;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [2:0] {
    VADD  = 3'b000,
    VSUB  = 3'b001,
    VAVG  = 3'b010,
    VMULS = 3'b011,
    VADDS = 3'b100,
    VSHR  = 3'b101,
    PASSA = 3'b110,
    PASSB = 3'b111
  } valu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } vexec_state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational 8-bit pixel lane ALU.
// Macro VEC_SAT_EN: when defined, VADDS saturates at 255; otherwise it wraps like VADD.
module vec_lane_alu
  import vec_pkg::*;
(
  input  valu_op_e op_i,
  input  lane_t    a_i,
  input  lane_t    b_i,
  input  lane_t    s_i,
  output lane_t    y_o
);

  logic [LANE_W:0] sum;
  logic [LANE_W:0] avg_sum;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  // a+b+1 never exceeds 511, so nine bits hold the rounding sum exactly.
  assign avg_sum = sum + (LANE_W + 1)'(1);

  // Per-lane opcode decode.
  always_comb begin
    y_o = '0;
    unique case (op_i)
      VADD:  y_o = sum[LANE_W-1:0];
      VSUB:  y_o = a_i - b_i;
      VAVG:  y_o = avg_sum[LANE_W:1];
      VMULS: y_o = lane_t'(((2 * LANE_W)'(a_i) * (2 * LANE_W)'(s_i)) >> LANE_W);
`ifdef VEC_SAT_EN
      VADDS: y_o = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
`else
      VADDS: y_o = sum[LANE_W-1:0];
`endif
      VSHR:  y_o = a_i >> s_i[2:0];
      PASSA: y_o = a_i;
      PASSB: y_o = b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execute stage: processes 32 byte lanes, LANES_PER_CYCLE per cycle,
// stalling upstream while busy and emitting a one-cycle valid pulse with the result.
// Macro VEC_SAT_EN (see vec_lane_alu) turns opcode 100 into a saturating add.
module vec_exec_unit
  import vec_pkg::*;
#(
  parameter int unsigned LANES_PER_CYCLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       alu_op_i,
  input  logic [VEC_W-1:0] vrs1_i,
  input  logic [VEC_W-1:0] vrs2_i,
  input  logic [31:0]      scalar_i,
  input  logic [4:0]       rd_i,
  output logic             stall_o,
  output logic             out_valid_o,
  output logic [VEC_W-1:0] result_o,
  output logic [4:0]       rd_o,
  output logic             wr_vec_o
);

  localparam int unsigned N      = NUM_LANES / LANES_PER_CYCLE;
  localparam int unsigned CntW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ChunkW = LANES_PER_CYCLE * LANE_W;

  vexec_state_e     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  lane_t            s_q, s_d;
  valu_op_e         op_q, op_d;
  logic [4:0]       rd_q, rd_d;

  logic [31:0]       chunk_sh;
  logic [ChunkW-1:0] a_chunk, b_chunk, y_chunk;
  logic              accept;
  logic              unused_scalar;

  assign accept        = (state_q == IDLE) & start_i & ~flush_i;
  assign unused_scalar = ^scalar_i[31:LANE_W];
  assign chunk_sh      = 32'(cnt_q) * ChunkW;

  // Chunk mux: route the lanes selected by cnt to the lane ALUs.
  always_comb begin
    a_chunk = ChunkW'(a_q >> chunk_sh);
    b_chunk = ChunkW'(b_q >> chunk_sh);
  end

  for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
    vec_lane_alu u_lane (
      .op_i (op_q),
      .a_i  (a_chunk[j*LANE_W +: LANE_W]),
      .b_i  (b_chunk[j*LANE_W +: LANE_W]),
      .s_i  (s_q),
      .y_o  (y_chunk[j*LANE_W +: LANE_W])
    );
  end

  // FSM next state, operand capture and chunked result write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = vrs1_i;
          b_d     = vrs2_i;
          s_d     = scalar_i[LANE_W-1:0];
          op_d    = valu_op_e'(alu_op_i);
          rd_d    = rd_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          // Abort: lanes written so far stay in result_q.
          state_d = IDLE;
        end else begin
          result_d = (result_q & ~(VEC_W'({ChunkW{1'b1}}) << chunk_sh)) |
                     (VEC_W'(y_chunk) << chunk_sh);
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) state_d = DONE;
        end
      end
      // Upstream still holds the finished instruction, so start_i is ignored here.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      op_q     <= VADD;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign stall_o     = (state_q == BUSY) | accept;
  assign out_valid_o = (state_q == DONE);
  assign wr_vec_o    = (state_q == DONE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit: one instance with 8 lanes/cycle (A), one with 1 (B).
module tb_vec_exec_unit;
  import vec_pkg::*;

  typedef struct {
    logic [255:0] res;
    logic [4:0]   rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic         a_start, a_flush, b_start, b_flush;
  logic [2:0]   a_op, b_op;
  logic [255:0] a_v1, a_v2, b_v1, b_v2;
  logic [31:0]  a_sc, b_sc;
  logic [4:0]   a_rd, b_rd;
  logic         a_stall, a_valid, a_wr, b_stall, b_valid, b_wr;
  logic [255:0] a_res, b_res;
  logic [4:0]   a_rd_o, b_rd_o;

  exp_t qa[$];
  exp_t qb[$];
  int   a_vt[$];

  vec_exec_unit #(.LANES_PER_CYCLE(8)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .start_i     (a_start),
    .flush_i     (a_flush),
    .alu_op_i    (a_op),
    .vrs1_i      (a_v1),
    .vrs2_i      (a_v2),
    .scalar_i    (a_sc),
    .rd_i        (a_rd),
    .stall_o     (a_stall),
    .out_valid_o (a_valid),
    .result_o    (a_res),
    .rd_o        (a_rd_o),
    .wr_vec_o    (a_wr)
  );

  vec_exec_unit #(.LANES_PER_CYCLE(1)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start_i     (b_start),
    .flush_i     (b_flush),
    .alu_op_i    (b_op),
    .vrs1_i      (b_v1),
    .vrs2_i      (b_v2),
    .scalar_i    (b_sc),
    .rd_i        (b_rd),
    .stall_o     (b_stall),
    .out_valid_o (b_valid),
    .result_o    (b_res),
    .rd_o        (b_rd_o),
    .wr_vec_o    (b_wr)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] splat(input logic [7:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Reference lane model used for the all-opcode sweep.
  function automatic logic [7:0] ref_lane(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] s);
    logic [8:0]  t;
    logic [15:0] p;
    t = {1'b0, a} + {1'b0, b};
    p = {8'd0, a} * {8'd0, s};
    case (op)
      3'd0: return t[7:0];
      3'd1: return a - b;
      3'd2: begin t = t + 9'd1; return t[8:1]; end
      3'd3: return p[15:8];
`ifdef VEC_SAT_EN
      3'd4: return t[8] ? 8'hFF : t[7:0];
`else
      3'd4: return t[7:0];
`endif
      3'd5: return a >> s[2:0];
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  function automatic logic [255:0] ref_vec(input logic [2:0] op, input logic [255:0] a,
                                           input logic [255:0] b, input logic [7:0] s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = ref_lane(op, a[i*8 +: 8], b[i*8 +: 8], s);
    return r;
  endfunction

  // Monitor A: pop and compare on every valid pulse.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && a_valid) begin
      a_vt.push_back(cyc);
      if (qa.size() == 0) chk("a_unexpected_valid", a_valid, 0);
      else begin
        e = qa.pop_front();
        chk("a_result", a_res, e.res);
        chk("a_rd", a_rd_o, e.rd);
        chk("a_wr_vec", a_wr, 1);
      end
    end
  end

  // Monitor B: pop and compare on every valid pulse.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && b_valid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", b_valid, 0);
      else begin
        e = qb.pop_front();
        chk("b_result", b_res, e.res);
        chk("b_rd", b_rd_o, e.rd);
        chk("b_wr_vec", b_wr, 1);
      end
    end
  end

  task automatic issue(input bit sel, input logic [2:0] op, input logic [255:0] v1,
                       input logic [255:0] v2, input logic [7:0] sc, input logic [4:0] rd);
    if (sel) begin
      b_op = op; b_v1 = v1; b_v2 = v2; b_sc = {24'hABCDEF, sc}; b_rd = rd; b_start = 1'b1;
    end else begin
      a_op = op; a_v1 = v1; a_v2 = v2; a_sc = {24'hABCDEF, sc}; a_rd = rd; a_start = 1'b1;
    end
  endtask

  task automatic push(input bit sel, input logic [255:0] res, input logic [4:0] rd);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    if (sel) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Count stall/valid cycles from the issue cycle (t=0) onward.
  task automatic run(input bit sel, input int n, input bit hold,
                     output int stall_n, output int valid_n, output int valid_t);
    stall_n = 0; valid_n = 0; valid_t = -1;
    for (int t = 0; t < n + 8; t++) begin
      @(negedge clk);
      if (sel ? b_stall : a_stall) stall_n++;
      if (sel ? b_valid : a_valid) begin
        valid_n++;
        if (valid_t < 0) valid_t = t;
      end
      @(posedge clk); #1;
      if ((!hold && t == 0) || (hold && t == n + 1)) begin
        if (sel) b_start = 1'b0;
        else a_start = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input bit sel);
    int k;
    k = 0;
    @(negedge clk);
    while (!(sel ? b_valid : a_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!(sel ? b_valid : a_valid)) chk("valid_timeout", sel ? b_valid : a_valid, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sn, vn, vt;
    logic [255:0] va, vb, vadds_vec, part, mask;

    rst = 1'b1;
    a_start = 0; a_flush = 0; a_op = 0; a_v1 = '0; a_v2 = '0; a_sc = '0; a_rd = '0;
    b_start = 0; b_flush = 0; b_op = 0; b_v1 = '0; b_v2 = '0; b_sc = '0; b_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_result", a_res, '0);
    chk("rst_a_rd", a_rd_o, '0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_wr", a_wr, 0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_stall", b_stall, 0);
    @(posedge clk); #1;

    // VAVG on 8 lanes/cycle: 0x10,0x21 -> 0x19
    issue(0, VAVG, splat(8'h10), splat(8'h21), 8'h00, 5'd5);
    push(0, splat(8'h19), 5'd5);
    run(0, 4, 0, sn, vn, vt);
    chk("vavg_stall_cycles", sn, 5);
    chk("vavg_valid_count", vn, 1);
    chk("vavg_valid_cycle", vt, 5);

    // Reset in the middle of BUSY
    issue(0, VADD, splat(8'h01), splat(8'h01), 8'h00, 5'd3);
    @(posedge clk); #1 a_start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_result", a_res, '0);
    chk("midrst_rd", a_rd_o, '0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_stall", a_stall, 0);
    repeat (6) @(posedge clk);
    #1;

    // VADDS: saturates only with VEC_SAT_EN
`ifdef VEC_SAT_EN
    vadds_vec = splat(8'hFF);
`else
    vadds_vec = splat(8'h10);
`endif
    issue(0, VADDS, splat(8'hF0), splat(8'h20), 8'h00, 5'd7);
    push(0, vadds_vec, 5'd7);
    run(0, 4, 0, sn, vn, vt);
    chk("vadds_valid_count", vn, 1);

    // Flush on the second BUSY cycle: lanes 0-7 written, lanes 16-31 untouched
    for (int i = 0; i < 32; i++) va[i*8 +: 8] = 8'(i + 8'h40);
    issue(0, VSUB, va, splat(8'h01), 8'h00, 5'd12);
    @(posedge clk); #1 a_start = 1'b0;
    @(posedge clk); #1 a_flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", a_stall, 1);
    @(posedge clk); #1 a_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall", a_stall, 0);
    part = vadds_vec;
    mask = '1;
    for (int i = 0; i < 8; i++) part[i*8 +: 8] = 8'(i + 8'h3F);
    mask[64 +: 64] = '0;
    chk("flush_partial_result", a_res & mask, part & mask);
    chk("flush_rd_captured", a_rd_o, 5'd12);
    vn = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (a_valid) vn++;
    end
    chk("flush_no_valid", vn, 0);
    @(posedge clk); #1;

    // start together with flush in IDLE: no accept
    issue(0, PASSA, splat(8'h55), splat(8'h66), 8'h00, 5'd20);
    a_flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", a_stall, 0);
    @(posedge clk); #1 a_start = 1'b0; a_flush = 1'b0;
    sn = 0; vn = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (a_stall) sn++;
      if (a_valid) vn++;
    end
    chk("flush_start_no_busy", sn, 0);
    chk("flush_start_no_valid", vn, 0);
    @(posedge clk); #1;

    // Back-to-back VADD: second accept in the IDLE cycle after DONE
    a_vt.delete();
    issue(0, VADD, splat(8'h01), splat(8'h02), 8'h00, 5'd1);
    push(0, splat(8'h03), 5'd1);
    push(0, splat(8'h00), 5'd2);
    wait_valid(0);
    @(posedge clk); #1;
    issue(0, VADD, splat(8'hFF), splat(8'h01), 8'h00, 5'd2);
    @(posedge clk); #1 a_start = 1'b0;
    wait_valid(0);
    @(posedge clk); #1;
    chk("b2b_pulse_count", a_vt.size(), 2);
    if (a_vt.size() == 2) chk("b2b_period", a_vt[1] - a_vt[0], 6);

    // All-opcode sweep with lane-varying data
    for (int i = 0; i < 32; i++) begin
      va[i*8 +: 8] = 8'(i * 9 + 5);
      vb[i*8 +: 8] = 8'(255 - i * 3);
    end
    for (int op = 0; op < 8; op++) begin
      issue(0, 3'(op), va, vb, 8'h35, 5'(op + 16));
      push(0, ref_vec(3'(op), va, vb, 8'h35), 5'(op + 16));
      @(posedge clk); #1 a_start = 1'b0;
      wait_valid(0);
      @(posedge clk); #1;
    end

    // VMULS on 1 lane/cycle, start held through DONE: 0xFF*0x80>>8 = 0x7F
    issue(1, VMULS, splat(8'hFF), splat(8'h33), 8'h80, 5'd9);
    push(1, splat(8'h7F), 5'd9);
    run(1, 32, 1, sn, vn, vt);
    chk("vmuls_stall_cycles", sn, 33);
    chk("vmuls_valid_count", vn, 1);
    chk("vmuls_valid_cycle", vt, 33);

    repeat (4) @(posedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
